mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-ported, multi-cycle main memory between the instruction-fetch stage and the data-memory stage of the 5-stage pipeline. Owns the backend request handshake and generates the fetch and data stall signals that the hazard logic folds into its NOP/hold decisions. Handles branch/jump flushes of in-flight fetches. Data accesses have priority, and a starvation guard keeps fetch moving.

## Interface
Parameters:
- AW, 16, address width
- DW, 16, data width
- STARVE_MAX, 4, number of consecutive data grants allowed while a fetch waits; range 1..15

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  AW  fetch address
- if_flush  in  1  branch/jump taken; cancels the current or pending fetch
- dm_rd  in  1  data read request; held until dm_done
- dm_wr  in  1  data write request; held until dm_done; wins if asserted together with dm_rd
- dm_addr  in  AW  data address
- dm_wdata  in  DW  write data
- if_done  out  1  fetch complete (combinational, 1 cycle)
- if_rdata  out  DW  fetched word; valid with if_done
- dm_done  out  1  data access complete (combinational, 1 cycle)
- dm_rdata  out  DW  read word; valid with dm_done on reads
- if_stall  out  1  if_req & ~if_done
- dm_stall  out  1  (dm_rd|dm_wr) & ~dm_done
- mem_en  out  1  backend request; level, held until mem_done
- mem_wr  out  1  backend write strobe
- mem_addr  out  AW  backend address
- mem_wdata  out  DW  backend write data
- mem_rdata  in  DW  backend read data; valid with mem_done
- mem_done  in  1  backend completion; sampled only while mem_en=1
- busy  out  1  state != IDLE

## Operation
- States: IDLE, BUSY_IF, BUSY_DM, KILL_IF.
- IDLE grant rules are evaluated each cycle. D = dm_rd|dm_wr and F = if_req & ~if_flush.
  - D & F & (cnt==STARVE_MAX): grant fetch, go to BUSY_IF.
  - Otherwise D: grant data, go to BUSY_DM.
  - Otherwise F: grant fetch, go to BUSY_IF.
  - Neither: stay in IDLE.
- On grant, mem_addr, mem_wr and mem_wdata are registered from the winner, and mem_en is set. Fetch grants use mem_wr=0.
- BUSY_DM with mem_done:
  - dm_done=1 and dm_rdata=mem_rdata in that cycle.
  - Next state is IDLE and mem_en clears.
- BUSY_IF with mem_done:
  - if_done=~if_flush and if_rdata=mem_rdata.
  - Next state is IDLE.
- BUSY_IF with if_flush and no mem_done: go to KILL_IF.
- KILL_IF: wait for mem_done, keep if_done=0, then go to IDLE. This drains the abandoned fetch.
- Starvation counter cnt (4 bits):
  - A data grant with if_req=1 sets cnt=cnt+1, saturating at STARVE_MAX.
  - A data grant with if_req=0 sets cnt=0.
  - Any fetch grant sets cnt=0.
- mem_done outside BUSY_*/KILL_IF is ignored.
- if_done and dm_done are never asserted together. They are never asserted in IDLE.

## Timing
- Reset values: state=IDLE, cnt=0, mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0. All combinational outputs are then 0.
- Reset asserted mid-transaction returns to IDLE immediately and drops mem_en. The backend transaction is abandoned and no done pulse is generated.
- Grant takes 1 cycle in IDLE. mem_en rises the cycle after the request is first seen in IDLE.
- Minimum transaction length is 2 cycles: 1 IDLE cycle plus 1 BUSY cycle with mem_done. With a backend latency of L cycles after mem_en rises, done fires L cycles after grant.
- Done is combinational with mem_done, so the requesting stage advances on the same edge. The next grant is evaluated in the following IDLE cycle, which gives 1 bubble between back-to-back transactions.
- if_flush in IDLE suppresses only that cycle's fetch grant.
- if_flush in the same cycle as mem_done in BUSY_IF: if_done=0 and the next state is IDLE.
- Requesters must hold the request and its addr/wdata stable until done. The arbiter uses only the values registered at grant.

## Structure
- Shared package/include mem_arb_defs holds the state encodings (2-bit) and the default AW/DW.
- One sub-module, starve_cnt: a saturating counter with inputs inc, clr and limit, and output at_max.

## Test plan
- Reset then lone fetch: if_req=1, addr=0x0040, backend L=3. Required: mem_en rises at cycle 1, if_done at cycle 3 with if_rdata=mem_rdata, if_stall=1 for cycles 0–2.
- Simultaneous: if_req and dm_rd both asserted. Required: data is granted first, dm_done, 1 IDLE bubble, then fetch is granted.
- Starvation with STARVE_MAX=4: dm_rd held continuously with new addresses while if_req=1. Required: 4 data grants, then a fetch grant, and cnt reads 0 after it.
- Flush during fetch: if_flush in the 2nd BUSY_IF cycle, L=4. Required: state goes to KILL_IF, if_done stays 0 on mem_done, then IDLE. Next, dm_wr is granted with mem_wr=1.
- Flush coincident with mem_done in BUSY_IF. Required: if_done=0 and state goes to IDLE the next cycle.
- Async reset in BUSY_DM. Required: mem_en=0 and busy=0 immediately, no dm_done, and a dm_rd held after reset release is re-granted.

Source files
------------

// File: rtl/mem_arb_defs.sv
// rtl/mem_arb_defs.sv - shared state encodings and default widths for mem_arbiter
// Purpose: arbiter FSM state type, default address/data widths, starvation counter width.
package mem_arb_defs;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_DM = 2'd2,
        ST_KILL_IF = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_starve_cnt.sv
// rtl/mem_arbiter_starve_cnt.sv - saturating starvation counter for the fetch requester
// Purpose: counts consecutive data grants taken while a fetch waits.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   inc          data grant while fetch waiting (saturates at limit)
//   clr          fetch grant, or data grant with no fetch waiting
//   limit        saturation value
//   at_max       count has reached limit
module starve_cnt
    import mem_arb_defs::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         at_max
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt < limit)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign at_max = (r_cnt == limit);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for the shared single-ported main memory
// Purpose: grants the backend to the fetch or data stage (data first, with a
//   starvation guard for fetch), drives the backend handshake, produces done
//   and stall strobes, and drains fetches abandoned by a branch/jump flush.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   if_req/if_addr/if_flush       fetch request, address, flush
//   dm_rd/dm_wr/dm_addr/dm_wdata  data request (write wins), address, write data
//   if_done/if_rdata              fetch completion and word
//   dm_done/dm_rdata              data completion and read word
//   if_stall/dm_stall             stage stall signals
//   mem_en/mem_wr/mem_addr/mem_wdata/mem_rdata/mem_done  backend handshake
//   busy                          arbiter not idle
module mem_arbiter
    import mem_arb_defs::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    input  logic          dm_rd,
    input  logic          dm_wr,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    output logic          dm_done,
    output logic [DW-1:0] dm_rdata,
    output logic          if_stall,
    output logic          dm_stall,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_done,
    output logic          busy
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_MAX);

    arb_state_t    r_state;
    arb_state_t    w_next;
    logic          w_d;
    logic          w_f;
    logic          w_at_max;
    logic          w_grant_if;
    logic          w_grant_dm;
    logic          r_mem_en;
    logic          r_mem_wr;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;

    assign w_d = dm_rd | dm_wr;
    // A flush in IDLE suppresses only this cycle's fetch grant.
    assign w_f = if_req & ~if_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_grant_if = 1'b0;
        w_grant_dm = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_d && w_f && w_at_max) begin
                    w_grant_if = 1'b1;
                    w_next     = ST_BUSY_IF;
                end else if (w_d) begin
                    w_grant_dm = 1'b1;
                    w_next     = ST_BUSY_DM;
                end else if (w_f) begin
                    w_grant_if = 1'b1;
                    w_next     = ST_BUSY_IF;
                end
            end
            ST_BUSY_IF: begin
                if (mem_done) begin
                    w_next = ST_IDLE;
                end else if (if_flush) begin
                    w_next = ST_KILL_IF;
                end
            end
            ST_BUSY_DM: begin
                if (mem_done) begin
                    w_next = ST_IDLE;
                end
            end
            ST_KILL_IF: begin
                // The backend cannot be cancelled, so the stale fetch is drained silently.
                if (mem_done) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Backend request is registered at grant so requesters' later changes cannot leak in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_grant_if) begin
            r_mem_en   <= 1'b1;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= if_addr;
        end else if (w_grant_dm) begin
            r_mem_en    <= 1'b1;
            r_mem_wr    <= dm_wr;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
        end else if ((r_state != ST_IDLE) && mem_done) begin
            r_mem_en <= 1'b0;
            r_mem_wr <= 1'b0;
        end
    end

    starve_cnt #(
        .W (CNT_W)
    ) u_starve_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (w_grant_dm & if_req),
        .clr    (w_grant_if | (w_grant_dm & ~if_req)),
        .limit  (LIMIT),
        .at_max (w_at_max)
    );

    assign if_done   = (r_state == ST_BUSY_IF) & mem_done & ~if_flush;
    assign dm_done   = (r_state == ST_BUSY_DM) & mem_done;
    assign if_rdata  = if_done ? mem_rdata : '0;
    assign dm_rdata  = dm_done ? mem_rdata : '0;
    assign if_stall  = if_req & ~if_done;
    assign dm_stall  = w_d & ~dm_done;
    assign busy      = (r_state != ST_IDLE);
    assign mem_en    = r_mem_en;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_flush, dm_rd, dm_wr, mem_done;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata, mem_rdata;
    logic          if_done, dm_done, if_stall, dm_stall, mem_en, mem_wr, busy;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .if_done(if_done), .if_rdata(if_rdata), .dm_done(dm_done), .dm_rdata(dm_rdata),
        .if_stall(if_stall), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .busy(busy)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the backend (0 none, 1 fetch, 2 data, 3 flushed fetch),
    // how many data grants in a row were taken while fetch waited, and the granted request.
    int            m_owner;
    int            m_streak;
    logic [AW-1:0] m_addr;
    logic          m_wr;
    logic [DW-1:0] m_wdata;
    int            bk_cnt, bk_lat, force_lat;
    bit            exp_if_done, exp_dm_done, last_if_done, last_dm_done;

    task automatic model_reset();
        m_owner      = 0;
        m_streak     = 0;
        bk_cnt       = 0;
        last_if_done = 1'b0;
        last_dm_done = 1'b0;
    endtask

    // Drive the backend for this cycle, let logic settle, compare every output to the model.
    task automatic settle();
        if (m_owner != 0) begin
            bk_cnt++;
            mem_done = (bk_cnt >= bk_lat);
        end else begin
            mem_done = 1'($urandom_range(0, 1));
        end
        mem_rdata = DW'($urandom);
        #2;
        exp_if_done = (m_owner == 1) && mem_done && !if_flush;
        exp_dm_done = (m_owner == 2) && mem_done;
        chk("if_done", 32'(if_done), 32'(exp_if_done));
        chk("dm_done", 32'(dm_done), 32'(exp_dm_done));
        if (exp_if_done) chk("if_rdata", 32'(if_rdata), 32'(mem_rdata));
        if (exp_dm_done && !m_wr) chk("dm_rdata", 32'(dm_rdata), 32'(mem_rdata));
        chk("if_stall", 32'(if_stall), 32'(if_req && !exp_if_done));
        chk("dm_stall", 32'(dm_stall), 32'((dm_rd || dm_wr) && !exp_dm_done));
        chk("busy", 32'(busy), 32'(m_owner != 0));
        chk("mem_en", 32'(mem_en), 32'(m_owner != 0));
        if (m_owner != 0) begin
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("mem_wr", 32'(mem_wr), 32'(m_wr));
            if (m_owner == 2 && m_wr) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        end
    endtask

    // Clock edge, then advance the model with the inputs that were present during the cycle.
    task automatic advance();
        bit d, f, granted;
        @(posedge clk);
        #1;
        last_if_done = exp_if_done;
        last_dm_done = exp_dm_done;
        granted = 1'b0;
        if (m_owner == 0) begin
            d = dm_rd || dm_wr;
            f = if_req && !if_flush;
            if (f && (!d || m_streak == SMAX)) begin
                m_owner  = 1;
                m_addr   = if_addr;
                m_wr     = 1'b0;
                m_streak = 0;
                granted  = 1'b1;
            end else if (d) begin
                m_owner  = 2;
                m_addr   = dm_addr;
                m_wr     = dm_wr;
                m_wdata  = dm_wdata;
                m_streak = if_req ? ((m_streak + 1 > SMAX) ? SMAX : m_streak + 1) : 0;
                granted  = 1'b1;
            end
        end else if (mem_done) begin
            m_owner = 0;
        end else if (m_owner == 1 && if_flush) begin
            m_owner = 3;
        end
        if (granted) begin
            bk_cnt = 0;
            bk_lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, 4));
        end
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndm, nfetch, wait_n, pick;
        int seq[$];
        bit prev_flush;

        rst = 1'b0; if_req = 0; if_flush = 0; dm_rd = 0; dm_wr = 0; mem_done = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0; force_lat = 0;
        model_reset();
        #2;
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_wr", 32'(mem_wr), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dones", 32'({if_done, dm_done, if_stall, dm_stall}), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Lone fetch, backend latency 3.
        force_lat = 3; if_req = 1; if_addr = 16'h0040;
        settle(); chk("lf_c0_stall", 32'(if_stall), 1); chk("lf_c0_en", 32'(mem_en), 0); advance();
        settle(); chk("lf_c1_en", 32'(mem_en), 1); chk("lf_c1_addr", 32'(mem_addr), 32'h40);
        chk("lf_c1_stall", 32'(if_stall), 1); advance();
        settle(); chk("lf_c2_stall", 32'(if_stall), 1); chk("lf_c2_done", 32'(if_done), 0); advance();
        settle(); chk("lf_c3_done", 32'(if_done), 1); chk("lf_c3_rdata", 32'(if_rdata), 32'(mem_rdata));
        chk("lf_c3_stall", 32'(if_stall), 0); advance();
        if_req = 0;

        // Fetch and data read together: data first, one bubble, then fetch.
        force_lat = 2; if_req = 1; if_addr = 16'h0100; dm_rd = 1; dm_addr = 16'h0200;
        cyc();
        settle(); chk("sim_c1_addr", 32'(mem_addr), 32'h200); chk("sim_c1_wr", 32'(mem_wr), 0); advance();
        settle(); chk("sim_c2_dmdone", 32'(dm_done), 1); chk("sim_c2_ifdone", 32'(if_done), 0); advance();
        dm_rd = 0;
        settle(); chk("sim_c3_bubble", 32'(busy), 0); chk("sim_c3_en", 32'(mem_en), 0); advance();
        settle(); chk("sim_c4_en", 32'(mem_en), 1); chk("sim_c4_addr", 32'(mem_addr), 32'h100); advance();
        settle(); chk("sim_c5_ifdone", 32'(if_done), 1); advance();
        if_req = 0;

        // Starvation guard: continuous reads with a waiting fetch.
        force_lat = 1; if_req = 1; if_addr = 16'h0300; dm_rd = 1; dm_addr = 16'h1000;
        ndm = 0; nfetch = 0; wait_n = 0;
        while (nfetch < 2 && wait_n < 60) begin
            settle();
            if (if_done) begin seq.push_back(ndm); ndm = 0; nfetch++; end
            if (dm_done) ndm++;
            advance();
            if (last_dm_done) dm_addr = dm_addr + 16'd1;
            if (last_if_done) if_addr = if_addr + 16'd2;
            wait_n++;
        end
        chk("starve_fetches", 32'(nfetch), 2);
        chk("starve_first_run", 32'((seq.size() >= 1) ? seq[0] : -1), 4);
        chk("starve_after_clear", 32'((seq.size() >= 2) ? seq[1] : -1), 4);
        if_req = 0; dm_rd = 0;
        cyc();

        // Flush in the second BUSY_IF cycle, latency 4, then a write.
        force_lat = 4; if_req = 1; if_addr = 16'h0500;
        cyc();
        cyc();
        if_flush = 1;
        settle(); chk("fl_c2_busy", 32'(busy), 1); advance();
        if_flush = 0; if_req = 0; dm_wr = 1; dm_addr = 16'h0600; dm_wdata = 16'hBEEF;
        settle(); chk("fl_c3_kill_busy", 32'(busy), 1); chk("fl_c3_en", 32'(mem_en), 1); advance();
        settle(); chk("fl_c4_memdone", 32'(mem_done), 1); chk("fl_c4_ifdone", 32'(if_done), 0);
        chk("fl_c4_dmdone", 32'(dm_done), 0); advance();
        settle(); chk("fl_c5_idle", 32'(busy), 0); advance();
        settle(); chk("fl_c6_wr", 32'(mem_wr), 1); chk("fl_c6_addr", 32'(mem_addr), 32'h600);
        chk("fl_c6_wdata", 32'(mem_wdata), 32'hBEEF); advance();
        wait_n = 0;
        while (!last_dm_done && wait_n < 10) begin cyc(); wait_n++; end
        chk("fl_write_done", 32'(last_dm_done), 1);
        dm_wr = 0;

        // Flush coincident with mem_done.
        force_lat = 2; if_req = 1; if_addr = 16'h0700;
        cyc();
        cyc();
        if_flush = 1;
        settle(); chk("co_memdone", 32'(mem_done), 1); chk("co_ifdone", 32'(if_done), 0); advance();
        if_flush = 0; if_req = 0;
        settle(); chk("co_idle", 32'(busy), 0); advance();

        // Asynchronous reset during a data access.
        force_lat = 4; dm_rd = 1; dm_addr = 16'h0800;
        cyc();
        cyc();
        settle();
        rst = 1'b0;
        #1;
        chk("ar_mem_en", 32'(mem_en), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_dmdone", 32'(dm_done), 0);
        @(posedge clk); #1;
        model_reset();
        rst = 1'b1;
        settle(); chk("ar_regrant_wait", 32'(mem_en), 0); advance();
        settle(); chk("ar_regrant_en", 32'(mem_en), 1); chk("ar_regrant_addr", 32'(mem_addr), 32'h800); advance();
        wait_n = 0;
        while (!last_dm_done && wait_n < 10) begin cyc(); wait_n++; end
        chk("ar_done", 32'(last_dm_done), 1);
        dm_rd = 0;

        // Randomized traffic against the model.
        force_lat = 0; prev_flush = 0;
        for (int c = 0; c < 400; c++) begin
            if (prev_flush) if_addr = AW'($urandom);
            if (last_if_done || !if_req) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = AW'($urandom);
            end
            if_flush = if_req && ($urandom_range(0, 9) == 0);
            prev_flush = if_flush;
            if (last_dm_done || !(dm_rd || dm_wr)) begin
                pick     = int'($urandom_range(0, 5));
                dm_rd    = (pick == 0 || pick == 2);
                dm_wr    = (pick == 1 || pick == 2);
                dm_addr  = AW'($urandom);
                dm_wdata = DW'($urandom);
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
